// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array feeder and its
// skew delay lines.
package systolic_pkg;

  localparam int DEFAULT_INPUT_WIDTH   = 16;
  localparam int DEFAULT_LANES         = 4;
  localparam int DEFAULT_VECTOR_LENGTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  // Number of DRAIN cycles needed to let the deepest lane catch up.
  function automatic int drainCycles(input int lanes);
    return (lanes > 1) ? lanes - 1 : 0;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Valid+data shift register of DEPTH stages; data is forced to zero on
// bubbles so an idle lane always presents 0.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds one tile of VECTOR_LENGTH beats into a systolic array edge, skewing
// lane i by i cycles and framing the tile with clear/done pulses.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int INPUT_WIDTH   = DEFAULT_INPUT_WIDTH,
  parameter int LANES         = DEFAULT_LANES,
  parameter int VECTOR_LENGTH = DEFAULT_VECTOR_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LANES*INPUT_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*INPUT_WIDTH-1:0] lane_data,
  output logic [LANES-1:0]             lane_valid,
  output logic                         clear_out,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W   = $clog2(VECTOR_LENGTH + 1);
  localparam int DRAIN_W = (LANES > 2) ? $clog2(LANES) : 1;

  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(VECTOR_LENGTH - 1);
  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(VECTOR_LENGTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((drainCycles(LANES) > 0) ? drainCycles(LANES) - 1 : 0);

  feeder_state_t      r_state;
  feeder_state_t      w_nextState;
  logic [CNT_W-1:0]   r_beatCnt;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic               w_accept;
  logic               w_lastBeat;

  assign w_accept   = in_valid & in_ready;
  assign w_lastBeat = w_accept && (r_beatCnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nextState = ST_CLEAR;
      ST_CLEAR:  w_nextState = ST_STREAM;
      ST_STREAM: if (w_lastBeat) w_nextState = (LANES > 1) ? ST_DRAIN : ST_DONE;
      ST_DRAIN:  if (r_drainCnt == DRAIN_LAST) w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    clear_out = 1'b0;
    done      = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_CLEAR:  clear_out = 1'b1;
      ST_STREAM: in_ready  = 1'b1;
      ST_DONE:   done      = 1'b1;
      default:   ;
    endcase
  end

  // The drain counter only runs in DRAIN, so it starts from 0 at the edge
  // of the last acceptance and DONE lines up with the deepest lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beatCnt  <= '0;
      r_drainCnt <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_beatCnt <= '0;
      end else if (w_accept && (r_beatCnt != FULL_COUNT)) begin
        r_beatCnt <= r_beatCnt + 1'b1;
      end
      if (r_state == ST_DRAIN) begin
        r_drainCnt <= r_drainCnt + 1'b1;
      end else begin
        r_drainCnt <= '0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    skew_delay_line #(
      .DEPTH(g + 1),
      .WIDTH(INPUT_WIDTH)
    ) u_skew (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_accept),
      .i_data (in_data[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .o_valid(lane_valid[g]),
      .o_data (lane_data[g*INPUT_WIDTH +: INPUT_WIDTH])
    );
  end

endmodule
